// File: rtl/bullet_bill_scheduler.sv
// BulletBill slot owner: fires bullets from the player row, sweeps them right on each
// movement tick, and reports same-color DDAVER hits over a valid/ready handshake.
module bullet_bill_scheduler #(
    parameter int NUM_BULLETS = 3,
    parameter int COLS        = 16,
    parameter int SPAWN_COL   = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               move_tick_i,
    input  logic                               fire_i,
    input  logic [11:0]                        fire_color_i,
    input  logic [3:0]                         blockieee_i,
    input  logic [0:4][0:5][11:0]              ddavers_i,
    input  logic                               hit_ready_i,
    output logic                               fire_ready_o,
    output logic [0:NUM_BULLETS-1][11:0]       bulletBillColor_o,
    output logic [0:NUM_BULLETS-1][3:0]        bulletBillXLoc_o,
    output logic [0:NUM_BULLETS-1][3:0]        bulletBillYLoc_o,
    output logic                               hit_valid_o,
    output logic [2:0]                         hit_row_o,
    output logic [2:0]                         hit_col_o,
    output logic                               busy_o,
    output logic                               tick_overrun_o
);

    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, REPORT} state_t;

    state_t                          state_q;
    logic [IW-1:0]                   idx_q;
    logic                            tick_pending_q;
    logic                            tick_overrun_q;
    logic                            hit_valid_q;
    logic [2:0]                      hit_row_q, hit_col_q;
    logic [0:NUM_BULLETS-1][11:0]    color_q;
    logic [0:NUM_BULLETS-1][3:0]     x_q, y_q;

    logic                            free_any;
    logic [IW-1:0]                   free_idx;
    logic [11:0]                     cur_color, enemy;
    logic [3:0]                      cur_x, cur_y, nx;
    logic                            at_edge, in_grid, last_slot, hit_d, fire_take;
    logic [2:0]                      r_d, c_d;

    // Lowest-index free slot; scanning downward leaves the lowest one winning.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int k = NUM_BULLETS - 1; k >= 0; k--) begin
            if (color_q[k] == 12'd0) begin
                free_any = 1'b1;
                free_idx = IW'(k);
            end
        end
    end

    // Slot under test this sweep cycle; edge check precedes the increment so X never wraps.
    always_comb begin
        cur_color = color_q[idx_q];
        cur_x     = x_q[idx_q];
        cur_y     = y_q[idx_q];
        nx        = cur_x + 4'd1;
        at_edge   = (cur_x == 4'(COLS - 1));
        in_grid   = cur_y[0] && (cur_y[3:1] <= 3'd4) && !nx[0] && (nx >= 4'd4) && (nx <= 4'd14);
        r_d       = cur_y[3:1];
        c_d       = nx[3:1] - 3'd2;
        enemy     = in_grid ? ddavers_i[r_d][c_d] : 12'd0;
        hit_d     = (cur_color != 12'd0) && !at_edge && (enemy != 12'd0) && (enemy == cur_color);
        last_slot = (idx_q == IW'(NUM_BULLETS - 1));
    end

    assign fire_ready_o = (state_q == IDLE) && free_any;
    assign fire_take    = fire_i && fire_ready_o && (fire_color_i != 12'd0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            tick_pending_q <= 1'b0;
            tick_overrun_q <= 1'b0;
            hit_valid_q    <= 1'b0;
            hit_row_q      <= 3'd0;
            hit_col_q      <= 3'd0;
            color_q        <= '0;
            x_q            <= '0;
            y_q            <= '0;
        end else begin
            tick_overrun_q <= 1'b0;
            if (state_q != IDLE && move_tick_i) begin
                if (tick_pending_q) tick_overrun_q <= 1'b1;
                else                tick_pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (fire_take) begin
                        color_q[free_idx] <= fire_color_i;
                        x_q[free_idx]     <= 4'(SPAWN_COL);
                        y_q[free_idx]     <= blockieee_i;
                    end
                    if (move_tick_i || tick_pending_q) begin
                        state_q        <= SWEEP;
                        idx_q          <= '0;
                        tick_pending_q <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (cur_color != 12'd0) begin
                        if (at_edge || enemy != 12'd0) begin
                            color_q[idx_q] <= 12'd0;
                            x_q[idx_q]     <= 4'd0;
                            y_q[idx_q]     <= 4'd0;
                        end else begin
                            x_q[idx_q] <= nx;
                        end
                    end
                    if (hit_d) begin
                        hit_valid_q <= 1'b1;
                        hit_row_q   <= r_d;
                        hit_col_q   <= c_d;
                        state_q     <= REPORT;
                    end else if (last_slot) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                REPORT: begin
                    if (hit_valid_q && hit_ready_i) begin
                        hit_valid_q <= 1'b0;
                        if (last_slot) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= SWEEP;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bulletBillColor_o = color_q;
    assign bulletBillXLoc_o  = x_q;
    assign bulletBillYLoc_o  = y_q;
    assign hit_valid_o       = hit_valid_q;
    assign hit_row_o         = hit_row_q;
    assign hit_col_o         = hit_col_q;
    assign busy_o            = (state_q != IDLE);
    assign tick_overrun_o    = tick_overrun_q;

endmodule
